// File: rtl/wr_guard_ctrl.sv
// rtl/wr_guard_ctrl.sv - write-path recovery sequencer (block AW, drain, reset, recover)
//
// Purpose:
//   Counts outstanding AXI writes from AW/B handshakes. On a fault from the
//   write transaction manager it blocks new AW traffic, waits for in-flight
//   writes to drain (bounded), pulses the subordinate reset and the manager
//   table clear, then keeps the path blocked until software acknowledges
//   (or leaves automatically when AutoRecover=1).
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   enable_i              fault handling enabled (faults ignored in RUN when 0)
//   timeout_i             soft fault: drain first, then reset
//   reset_req_i           hard fault: reset without draining
//   irq_clr_i             software acknowledge pulse
//   aw_valid_i/aw_ready_i AW handshake
//   b_valid_i/b_ready_i   B handshake
//   block_aw_o            gate AW toward the subordinate
//   rd_rst_o, slv_reset_o table clear / subordinate reset, high in RESET
//   irq_o                 sticky interrupt
//   busy_o                sequencer not in RUN
//   state_o               RUN=0, DRAIN=1, RESET=2, RECOVER=3
//   outstanding_o         live outstanding write count
//   drain_timeout_o       sticky: DRAIN left on budget rather than empty
//   fault_cnt_o           saturating count of accepted faults

module wr_guard_ctrl #(
   parameter int unsigned MaxWrTxns   = 8,
   parameter int unsigned ResetCycles = 16,
   parameter int unsigned DrainBudget = 256,
   parameter bit          AutoRecover = 1'b0
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic                               enable_i,
   input  logic                               timeout_i,
   input  logic                               reset_req_i,
   input  logic                               irq_clr_i,
   input  logic                               aw_valid_i,
   input  logic                               aw_ready_i,
   input  logic                               b_valid_i,
   input  logic                               b_ready_i,
   output logic                               block_aw_o,
   output logic                               rd_rst_o,
   output logic                               slv_reset_o,
   output logic                               irq_o,
   output logic                               busy_o,
   output logic [1:0]                         state_o,
   output logic [$clog2(MaxWrTxns+1)-1:0]     outstanding_o,
   output logic                               drain_timeout_o,
   output logic [7:0]                         fault_cnt_o
);

   localparam int unsigned OutW = $clog2(MaxWrTxns + 1);
   localparam int unsigned DrnW = $clog2(DrainBudget + 1);
   localparam int unsigned RstW = $clog2(ResetCycles + 1);

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_DRAIN   = 2'd1,
      ST_RESET   = 2'd2,
      ST_RECOVER = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [DrnW-1:0]   drain_cnt_q;
   logic [RstW-1:0]   rst_cnt_q;
   logic [OutW-1:0]   outstanding_q;
   logic              irq_q;
   logic              drain_to_q;
   logic [7:0]        fault_cnt_q;

   logic aw_hs, b_hs, hard_fault, soft_fault;
   logic drain_empty, drain_last, rst_last;
   logic fault_accept, set_drain_to, clear_irq;

   // AW is only counted while the gate is open, i.e. in RUN.
   assign aw_hs       = aw_valid_i & aw_ready_i & (state_q == ST_RUN);
   assign b_hs        = b_valid_i & b_ready_i;
   assign hard_fault  = enable_i & reset_req_i;
   assign soft_fault  = enable_i & timeout_i;
   assign drain_empty = (outstanding_q == '0);
   assign drain_last  = (drain_cnt_q == DrnW'(DrainBudget - 1));
   assign rst_last    = (rst_cnt_q == RstW'(ResetCycles - 1));

   always_comb begin
      state_d      = state_q;
      fault_accept = 1'b0;
      set_drain_to = 1'b0;
      clear_irq    = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (hard_fault) begin
               state_d      = ST_RESET;
               fault_accept = 1'b1;
            end else if (soft_fault) begin
               state_d      = ST_DRAIN;
               fault_accept = 1'b1;
            end else if (irq_clr_i) begin
               clear_irq = 1'b1;
            end
         end
         ST_DRAIN: begin
            // A hard fault cuts the drain short; an empty table beats the
            // budget, so drain_timeout only marks a genuine budget exit.
            if (hard_fault) begin
               state_d      = ST_RESET;
               fault_accept = 1'b1;
            end else if (drain_empty) begin
               state_d = ST_RESET;
            end else if (drain_last) begin
               state_d      = ST_RESET;
               set_drain_to = 1'b1;
            end
         end
         ST_RESET: begin
            if (rst_last) begin
               state_d = ST_RECOVER;
            end
         end
         ST_RECOVER: begin
            clear_irq = irq_clr_i;
            if (AutoRecover || irq_clr_i) begin
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q       <= ST_RUN;
         drain_cnt_q   <= '0;
         rst_cnt_q     <= '0;
         outstanding_q <= '0;
         irq_q         <= 1'b0;
         drain_to_q    <= 1'b0;
         fault_cnt_q   <= '0;
      end else begin
         state_q <= state_d;

         // Phase counters idle at zero so they start from zero on entry.
         drain_cnt_q <= (state_q == ST_DRAIN) ? drain_cnt_q + 1'b1 : '0;
         rst_cnt_q   <= (state_q == ST_RESET) ? rst_cnt_q + 1'b1 : '0;

         if (state_q == ST_RESET) begin
            outstanding_q <= '0;
         end else if (aw_hs && !b_hs && (outstanding_q != OutW'(MaxWrTxns))) begin
            outstanding_q <= outstanding_q + 1'b1;
         end else if (b_hs && !aw_hs && (outstanding_q != '0)) begin
            outstanding_q <= outstanding_q - 1'b1;
         end

         if (fault_accept) begin
            irq_q <= 1'b1;
         end else if (clear_irq) begin
            irq_q <= 1'b0;
         end

         if (set_drain_to) begin
            drain_to_q <= 1'b1;
         end else if (clear_irq) begin
            drain_to_q <= 1'b0;
         end

         if (fault_accept && (fault_cnt_q != 8'hFF)) begin
            fault_cnt_q <= fault_cnt_q + 8'd1;
         end
      end
   end

   assign block_aw_o      = (state_q != ST_RUN);
   assign busy_o          = (state_q != ST_RUN);
   assign rd_rst_o        = (state_q == ST_RESET);
   assign slv_reset_o     = (state_q == ST_RESET);
   assign state_o         = state_q;
   assign irq_o           = irq_q;
   assign outstanding_o   = outstanding_q;
   assign drain_timeout_o = drain_to_q;
   assign fault_cnt_o     = fault_cnt_q;

endmodule

// File: tb/tb_wr_guard_ctrl.sv
// tb/tb_wr_guard_ctrl.sv - scoreboard bench for wr_guard_ctrl

module tb_wr_guard_ctrl;

   localparam int MAXW = 8;
   localparam int RC   = 16;
   localparam int DB   = 256;

   localparam int P_RUN     = 0;
   localparam int P_DRAIN   = 1;
   localparam int P_RESET   = 2;
   localparam int P_RECOVER = 3;

   logic clk = 1'b0;
   logic rst_i = 1'b1;
   logic en = 1'b0, to = 1'b0, rr = 1'b0, clr = 1'b0;
   logic awv = 1'b0, awr = 1'b0, bv = 1'b0, br = 1'b0;

   logic       block_aw_o, rd_rst_o, slv_reset_o, irq_o, busy_o, drain_timeout_o;
   logic [1:0] state_o;
   logic [3:0] outstanding_o;
   logic [7:0] fault_cnt_o;

   wr_guard_ctrl #(
      .MaxWrTxns(MAXW), .ResetCycles(RC), .DrainBudget(DB), .AutoRecover(1'b0)
   ) dut (
      .clk_i(clk), .rst_i(rst_i), .enable_i(en), .timeout_i(to),
      .reset_req_i(rr), .irq_clr_i(clr), .aw_valid_i(awv), .aw_ready_i(awr),
      .b_valid_i(bv), .b_ready_i(br), .block_aw_o(block_aw_o), .rd_rst_o(rd_rst_o),
      .slv_reset_o(slv_reset_o), .irq_o(irq_o), .busy_o(busy_o), .state_o(state_o),
      .outstanding_o(outstanding_o), .drain_timeout_o(drain_timeout_o),
      .fault_cnt_o(fault_cnt_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       block;
      logic       rd_rst;
      logic       slv;
      logic       irq;
      logic       busy;
      logic [1:0] st;
      logic [3:0] outs;
      logic       dto;
      logic [7:0] fc;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_errs = 0;
   int   seen[4];

   // Reference model: phase, cycles spent in phase, counts and sticky flags.
   int m_phase, m_cyc, m_out, m_fc;
   bit m_irq, m_dto;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errs++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t cur_exp();
      exp_t e;
      e.block  = (m_phase != P_RUN);
      e.rd_rst = (m_phase == P_RESET);
      e.slv    = (m_phase == P_RESET);
      e.irq    = m_irq;
      e.busy   = (m_phase != P_RUN);
      e.st     = 2'(m_phase);
      e.outs   = 4'(m_out);
      e.dto    = m_dto;
      e.fc     = 8'(m_fc);
      return e;
   endfunction

   task automatic model_reset();
      m_phase = P_RUN; m_cyc = 0; m_out = 0; m_fc = 0; m_irq = 0; m_dto = 0;
   endtask

   task automatic model_update();
      int nxt;
      bit fault;
      nxt   = m_phase;
      fault = 0;
      case (m_phase)
         P_RUN: begin
            if (en && rr) begin nxt = P_RESET; fault = 1; end
            else if (en && to) begin nxt = P_DRAIN; fault = 1; end
            else if (clr) begin m_irq = 0; m_dto = 0; end
         end
         P_DRAIN: begin
            if (en && rr) begin nxt = P_RESET; fault = 1; end
            else if (m_out == 0) nxt = P_RESET;
            else if (m_cyc + 1 >= DB) begin nxt = P_RESET; m_dto = 1; end
         end
         P_RESET: begin
            if (m_cyc + 1 >= RC) nxt = P_RECOVER;
         end
         default: begin
            if (clr) begin nxt = P_RUN; m_irq = 0; m_dto = 0; end
         end
      endcase
      if (m_phase == P_RESET) m_out = 0;
      else begin
         m_out = m_out + ((awv && awr && m_phase == P_RUN) ? 1 : 0) - ((bv && br) ? 1 : 0);
         if (m_out < 0) m_out = 0;
         if (m_out > MAXW) m_out = MAXW;
      end
      if (fault) begin
         m_irq = 1;
         if (m_fc < 255) m_fc++;
      end
      if (nxt != m_phase) m_cyc = 0; else m_cyc++;
      m_phase = nxt;
   endtask

   task automatic step();
      @(posedge clk);
      if (rst_i) model_reset(); else model_update();
      exp_q.push_back(cur_exp());
      #2;
   endtask

   task automatic run_until(input int phase, input int bound, input string name);
      int k = 0;
      while (m_phase != phase && k < bound) begin
         step();
         k++;
      end
      if (m_phase != phase) begin
         n_checks++;
         n_errs++;
         $display("FAIL %s: phase bound of %0d cycles expired", name, bound);
      end
   endtask

   task automatic clear_seen();
      foreach (seen[i]) seen[i] = 0;
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         chk("block_aw", block_aw_o, mon_e.block);
         chk("rd_rst", rd_rst_o, mon_e.rd_rst);
         chk("slv_reset", slv_reset_o, mon_e.slv);
         chk("irq", irq_o, mon_e.irq);
         chk("busy", busy_o, mon_e.busy);
         chk("state", state_o, mon_e.st);
         chk("outstanding", outstanding_o, mon_e.outs);
         chk("drain_timeout", drain_timeout_o, mon_e.dto);
         chk("fault_cnt", fault_cnt_o, mon_e.fc);
         seen[state_o]++;
      end
   end

   initial begin
      model_reset();
      clear_seen();
      step();
      step();
      rst_i = 1'b0;
      en = 1'b1;
      step();
      chk("rst_state", state_o, 0);
      chk("rst_fcnt", fault_cnt_o, 0);

      // Three writes, timeout, B at +5..+7: 8 DRAIN cycles, 16 RESET cycles.
      awv = 1; awr = 1; repeat (3) step(); awv = 0; awr = 0;
      clear_seen();
      to = 1; step(); to = 0;
      repeat (4) step();
      bv = 1; br = 1; repeat (3) step(); bv = 0; br = 0;
      run_until(P_RECOVER, 40, "t1_recover");
      chk("t1_drain_len", seen[P_DRAIN], 8);
      chk("t1_reset_len", seen[P_RESET], RC);
      chk("t1_dto", drain_timeout_o, 0);
      chk("t1_fcnt", fault_cnt_o, 1);
      repeat (100) step();
      chk("t1_hold_recover", state_o, P_RECOVER);
      clr = 1; step(); clr = 0;
      chk("t1_run", state_o, P_RUN);
      chk("t1_irq_clr", irq_o, 0);
      chk("t1_unblock", block_aw_o, 0);

      // Acknowledge and new timeout together: the fault wins.
      clr = 1; to = 1; step(); clr = 0; to = 0;
      chk("t5_drain", state_o, P_DRAIN);
      chk("t5_irq", irq_o, 1);
      chk("t5_fcnt", fault_cnt_o, 2);
      run_until(P_RECOVER, 40, "t5_recover");
      clr = 1; step(); clr = 0;

      // Two stuck writes: budget exit after exactly DB cycles.
      awv = 1; awr = 1; repeat (2) step(); awv = 0; awr = 0;
      clear_seen();
      to = 1; step(); to = 0;
      run_until(P_RECOVER, 400, "t2_recover");
      chk("t2_drain_len", seen[P_DRAIN], DB);
      chk("t2_dto", drain_timeout_o, 1);
      chk("t2_out", outstanding_o, 0);
      clr = 1; step(); clr = 0;
      chk("t2_dto_clr", drain_timeout_o, 0);

      // Hard fault with 4 outstanding: straight to RESET, AW not counted there.
      awv = 1; awr = 1; repeat (4) step(); awv = 0; awr = 0;
      clear_seen();
      rr = 1; step(); rr = 0;
      chk("t3_reset", state_o, P_RESET);
      chk("t3_irq", irq_o, 1);
      awv = 1; awr = 1;
      run_until(P_RECOVER, 40, "t3_recover");
      awv = 0; awr = 0;
      chk("t3_no_drain", seen[P_DRAIN], 0);
      chk("t3_out", outstanding_o, 0);
      clr = 1; step(); clr = 0;

      // Counter corner cases.
      awv = 1; awr = 1; repeat (3) step();
      bv = 1; br = 1; repeat (10) step();
      chk("t4_same_cycle", outstanding_o, 3);
      awv = 0; awr = 0; repeat (5) step();
      chk("t4_floor", outstanding_o, 0);
      bv = 0; br = 0;
      awv = 1; awr = 1; repeat (9) step(); awv = 0; awr = 0;
      chk("t4_ceiling", outstanding_o, MAXW);
      bv = 1; br = 1; repeat (8) step(); bv = 0; br = 0;

      // Asynchronous reset in the fifth RESET cycle.
      rr = 1; step(); rr = 0;
      repeat (4) step();
      chk("t6_pre_slv", slv_reset_o, 1);
      rst_i = 1'b1;
      model_reset();
      exp_q.delete();
      exp_q.push_back(cur_exp());
      #1;
      chk("t6_slv_drop", slv_reset_o, 0);
      chk("t6_rd_rst_drop", rd_rst_o, 0);
      chk("t6_state", state_o, P_RUN);
      chk("t6_fcnt", fault_cnt_o, 0);
      step();
      rst_i = 1'b0;

      // Randomised traffic and faults.
      repeat (3000) begin
         en  = ($urandom_range(7) != 0);
         to  = ($urandom_range(15) == 0);
         rr  = ($urandom_range(31) == 0);
         clr = ($urandom_range(7) == 0);
         awv = $urandom_range(1);
         awr = $urandom_range(1);
         bv  = $urandom_range(1);
         br  = $urandom_range(1);
         step();
      end
      en = 1; to = 0; rr = 0; awv = 0; awr = 0; bv = 0; br = 0;
      clr = 1;
      run_until(P_RUN, 400, "rand_back_to_run");
      clr = 0;

      // Fault counter saturation.
      for (int i = 0; i < 260; i++) begin
         rr = 1; step(); rr = 0;
         run_until(P_RECOVER, 40, "sat_recover");
         clr = 1; step(); clr = 0;
      end
      chk("sat_fcnt", fault_cnt_o, 255);
      chk("sat_irq_clr", irq_o, 0);

      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

endmodule

// File: doc/wr_guard_ctrl.md
Name: wr_guard_ctrl

Overview:
- Recovery sequencer for the AXI write-monitor datapath.
- Tracks outstanding write transactions from AW/B handshakes.
- On a timeout or reset request from the write transaction manager, it:
  - blocks new AW traffic,
  - drains in-flight transactions (bounded wait),
  - pulses the subordinate reset and the manager table clear,
  - holds the path blocked until software acknowledges (or recovers automatically).
- Sits between the write transaction manager, the AW gating logic and the register file.

Parameters:
- MaxWrTxns, 8, maximum outstanding writes; counter width is $clog2(MaxWrTxns+1).
- ResetCycles, 16, number of cycles slv_reset_o/rd_rst_o stay asserted (>=1).
- DrainBudget, 256, maximum cycles spent in DRAIN (>=1).
- AutoRecover, 0, 1 = leave RECOVER without software clear.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- enable_i  in  1  fault handling enabled; when 0, faults are ignored in RUN.
- timeout_i  in  1  soft fault (budget timeout) from the write transaction manager.
- reset_req_i  in  1  hard fault (handshake timeout or unwanted B) from the manager.
- irq_clr_i  in  1  software acknowledge pulse.
- aw_valid_i  in  1  AW valid.
- aw_ready_i  in  1  AW ready.
- b_valid_i  in  1  B valid.
- b_ready_i  in  1  B ready.
- block_aw_o  out  1  gate AW valid/ready toward the subordinate.
- rd_rst_o  out  1  clear the manager linked-data/head-tail tables.
- slv_reset_o  out  1  subordinate reset request.
- irq_o  out  1  sticky interrupt.
- busy_o  out  1  state != RUN.
- state_o  out  2  RUN=0, DRAIN=1, RESET=2, RECOVER=3.
- outstanding_o  out  $clog2(MaxWrTxns+1)  live outstanding count.
- drain_timeout_o  out  1  sticky: DRAIN exited on budget, not on empty.
- fault_cnt_o  out  8  saturating count of accepted faults.

Behaviour:
- Reset: state RUN; all counters 0; all outputs 0.
- All outputs are registered or decoded from registered state; no combinational path from inputs to outputs.
- Outstanding counter:
  - +1 on AW handshake (aw_valid_i & aw_ready_i & !block_aw_o).
  - -1 on B handshake (b_valid_i & b_ready_i).
  - Both in the same cycle: unchanged.
  - Saturates at MaxWrTxns; a decrement at 0 is ignored.
  - Forced to 0 on every cycle in RESET.
- RUN:
  - block_aw_o=0.
  - If enable_i & reset_req_i: go to RESET (skip DRAIN).
  - Else if enable_i & timeout_i: go to DRAIN.
  - On either transition: irq_o<=1, fault_cnt_o increments (saturates at 255).
  - A fault and irq_clr_i in the same cycle: the fault wins.
- DRAIN:
  - block_aw_o=1; the drain counter starts at 0 on entry.
  - Go to RESET when outstanding==0, or when drain counter==DrainBudget-1.
  - Budget exit sets drain_timeout_o.
  - Empty and budget on the same cycle: empty wins; drain_timeout_o stays 0.
  - reset_req_i in DRAIN: go to RESET next cycle without setting drain_timeout_o.
- RESET:
  - block_aw_o=1, slv_reset_o=1, rd_rst_o=1 for exactly ResetCycles cycles, then go to RECOVER.
- RECOVER:
  - block_aw_o=1; slv_reset_o=0, rd_rst_o=0.
  - If AutoRecover=1: return to RUN after one cycle; irq_o stays set until irq_clr_i.
  - Else: wait for irq_clr_i, then go to RUN and clear irq_o, drain_timeout_o.
- irq_clr_i:
  - In RUN: clears irq_o and drain_timeout_o.
  - In DRAIN/RESET: ignored.
- Faults outside RUN (except reset_req_i in DRAIN): ignored; not counted.
- Asynchronous rst_i mid-sequence: immediately returns to RUN with every output at 0, including a deasserted slv_reset_o.

Test Plan:
- 3 AW handshakes, then timeout_i pulse, B responses at +5, +6, +7 cycles:
  - DRAIN for 8 cycles, then slv_reset_o/rd_rst_o high 16 cycles, then RECOVER.
  - drain_timeout_o=0; fault_cnt_o=1.
- 2 outstanding, no B, DrainBudget=256: DRAIN exits after exactly 256 cycles; drain_timeout_o=1; outstanding_o=0 after RESET.
- reset_req_i in RUN with 4 outstanding: RESET on the next cycle (no DRAIN); irq_o=1; AW valid during RESET is not counted.
- Same-cycle AW and B handshakes, 10 cycles: outstanding_o unchanged. B at count 0: stays 0. 9 AW with MaxWrTxns=8: stays 8.
- RECOVER with AutoRecover=0:
  - Stays for 100 cycles until irq_clr_i; then RUN, irq_o=0, block_aw_o=0.
  - irq_clr_i coincident with a new timeout_i in RUN: DRAIN entered; irq_o=1; fault_cnt_o=2.
- rst_i asserted on cycle 5 of RESET: slv_reset_o drops without waiting for a clock edge; state_o=0; fault_cnt_o=0.
